tile_c_writeback: RTL and testbench

- Output stage directly downstream of the systolic array inside gemm.
- Accepts finished C-tile result rows (COLS x 32-bit accumulators) from the array drain and buffers them in a 2-entry FIFO.
- Writes each row to the scratchpad memory port (interface_*) at tile_C_addr + row*C_stride, one row per granted cycle.
- Raises done once msize rows are written, which the GEMM_DIM status read reports as "GEMM done".

---
 rtl/tile_c_writeback.sv | 163 ++++++++++++++++
 tb/tb_tile_c_writeback.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_c_writeback.sv
// Writes finished C-tile rows from the systolic array drain to the scratchpad through a 2-entry FIFO.
// Optional build macro TILE_C_WB_RELU_EN clamps negative lanes to zero at the write port.
module tile_c_writeback #(
  parameter int COLS   = 4,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       tile_c_addr_i,
  input  logic [ADDR_W-1:0]       c_stride_i,
  input  logic [DIM_W-1:0]        msize_i,
  input  logic [DIM_W-1:0]        nsize_i,
  input  logic                    row_valid_i,
  input  logic [COLS*ACC_W-1:0]   row_data_i,
  output logic                    row_ready_o,
  input  logic                    mem_gnt_i,
  output logic                    interface_en_o,
  output logic                    interface_rdwr_o,
  output logic [ADDR_W-1:0]       interface_addr_o,
  output logic [COLS*ACC_W-1:0]   interface_wr_data_o,
  output logic [4:0]              interface_control_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [DIM_W-1:0]    msize_q, msize_d;
  logic [DIM_W-1:0]    nsize_q, nsize_d;
  logic [DIM_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [DIM_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic                done_zero_q, done_zero_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic [COLS*ACC_W-1:0] fifo_mem [2];
  logic [COLS*ACC_W-1:0] head_data;
  logic [DIM_W-1:0]      nsize_clamp;
  logic                  fifo_full, fifo_empty, push, pop, last_write;

  assign nsize_clamp = (nsize_i > DIM_W'(COLS)) ? DIM_W'(COLS) : nsize_i;
  assign fifo_full   = (count_q == 2'd2);
  assign fifo_empty  = (count_q == 2'd0);
  assign pop         = interface_en_o && mem_gnt_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign row_ready_o = (state_q == RUN) && (acc_cnt_q < msize_q) && (!fifo_full || pop);
  assign push        = row_valid_i && row_ready_o;
  assign last_write  = pop && ((wr_cnt_q + DIM_W'(1)) == msize_q);

  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_zero_q || last_write;
  assign interface_en_o      = !fifo_empty;
  assign interface_rdwr_o    = interface_en_o;
  assign interface_addr_o    = interface_en_o ? next_addr_q : '0;
  assign interface_control_o = interface_en_o ? 5'(nsize_q) : 5'd0;
  assign head_data           = fifo_mem[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
      logic [ACC_W-1:0] lane;
      logic             keep;
      assign lane = head_data[gi*ACC_W +: ACC_W];
`ifdef TILE_C_WB_RELU_EN
      assign keep = interface_en_o && (DIM_W'(gi) < nsize_q) && !lane[ACC_W-1];
`else
      assign keep = interface_en_o && (DIM_W'(gi) < nsize_q);
`endif
      assign interface_wr_data_o[gi*ACC_W +: ACC_W] = keep ? lane : '0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    next_addr_d = next_addr_q;
    msize_d     = msize_q;
    nsize_d     = nsize_q;
    wr_cnt_d    = wr_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    done_zero_d = 1'b0;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      wr_cnt_d    = wr_cnt_q + DIM_W'(1);
      next_addr_d = next_addr_q + stride_q;
    end
    if (push) begin
      acc_cnt_d = acc_cnt_q + DIM_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          stride_d    = c_stride_i;
          msize_d     = msize_i;
          nsize_d     = nsize_clamp;
          next_addr_d = tile_c_addr_i;
          wr_cnt_d    = '0;
          acc_cnt_d   = '0;
          // An empty tile completes immediately without touching memory.
          if (msize_i == '0 || nsize_i == '0) begin
            done_zero_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (push && ((acc_cnt_q + DIM_W'(1)) == msize_q)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (last_write) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      stride_q    <= '0;
      next_addr_q <= '0;
      msize_q     <= '0;
      nsize_q     <= '0;
      wr_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      done_zero_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      next_addr_q <= next_addr_d;
      msize_q     <= msize_d;
      nsize_q     <= nsize_d;
      wr_cnt_q    <= wr_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      done_zero_q <= done_zero_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= row_data_i;
    end
  end

endmodule

// File: tb/tb_tile_c_writeback.sv
// Scoreboard bench for tile_c_writeback: expected row writes are queued on acceptance and checked on grant.
`timescale 1ns/1ps
module tb_tile_c_writeback;
  localparam int COLS = 4, ACC_W = 32, ADDR_W = 32, DIM_W = 5;
  localparam int RW = COLS * ACC_W;

  logic              clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [ADDR_W-1:0] tile_c_addr_i = '0, c_stride_i = '0;
  logic [DIM_W-1:0]  msize_i = '0, nsize_i = '0;
  logic              row_valid_i = 1'b0, mem_gnt_i = 1'b0;
  logic [RW-1:0]     row_data_i = '0;
  logic              row_ready_o, interface_en_o, interface_rdwr_o, busy_o, done_o;
  logic [ADDR_W-1:0] interface_addr_o;
  logic [RW-1:0]     interface_wr_data_o;
  logic [4:0]        interface_control_o;

  tile_c_writeback #(.COLS(COLS), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .tile_c_addr_i(tile_c_addr_i), .c_stride_i(c_stride_i),
    .msize_i(msize_i), .nsize_i(nsize_i),
    .row_valid_i(row_valid_i), .row_data_i(row_data_i), .row_ready_o(row_ready_o),
    .mem_gnt_i(mem_gnt_i), .interface_en_o(interface_en_o), .interface_rdwr_o(interface_rdwr_o),
    .interface_addr_o(interface_addr_o), .interface_wr_data_o(interface_wr_data_o),
    .interface_control_o(interface_control_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     data;
    logic [4:0]        ctrl;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] rows_q[$];
  int            checks = 0, passed = 0;
  int            done_cnt = 0, tile_writes = 0;
  logic [ADDR_W-1:0] m_base = '0, m_stride = '0;
  int            m_m = 0, m_n = 0, m_acc = 0;
  exp_t          mon_e;

  function automatic logic [RW-1:0] mkrow(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] r, input int n);
    logic [RW-1:0]    res;
    logic [ACC_W-1:0] v;
    int               lim;
    lim = (n > COLS) ? COLS : n;
    res = '0;
    for (int i = 0; i < COLS; i++) begin
      v = r[i*ACC_W +: ACC_W];
      if (i >= lim) v = '0;
`ifdef TILE_C_WB_RELU_EN
      if ($signed(v) < 0) v = '0;
`endif
      res[i*ACC_W +: ACC_W] = v;
    end
    return res;
  endfunction

  // Scoreboard: every granted write must match the oldest expected row.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (interface_en_o && mem_gnt_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected got addr=%0d data=%h required no write", interface_addr_o, interface_wr_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (interface_addr_o !== mon_e.addr || interface_wr_data_o !== mon_e.data ||
              interface_control_o !== mon_e.ctrl || interface_rdwr_o !== 1'b1)
            $display("FAIL write_row got addr=%0d data=%h ctrl=%0d rdwr=%b required addr=%0d data=%h ctrl=%0d rdwr=1",
                     interface_addr_o, interface_wr_data_o, interface_control_o, interface_rdwr_o,
                     mon_e.addr, mon_e.data, mon_e.ctrl);
          else passed++;
        end
        tile_writes++;
      end
      if (done_o) begin
        done_cnt++;
        checks++;
        if (tile_writes !== m_m)
          $display("FAIL done_timing got writes_at_done=%0d required %0d", tile_writes, m_m);
        else passed++;
      end
    end
  end

  task automatic start_tile(input logic [31:0] a, input logic [31:0] s, input int m, input int n, input bit upd);
    tile_c_addr_i = a; c_stride_i = s; msize_i = DIM_W'(m); nsize_i = DIM_W'(n); start_i = 1'b1;
    if (upd) begin
      m_base = a; m_stride = s; m_m = (m == 0 || n == 0) ? 0 : m; m_n = n; m_acc = 0; tile_writes = 0;
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; tile_c_addr_i = '1; c_stride_i = '1; msize_i = '1; nsize_i = '1;
  endtask

  task automatic accept_row();
    exp_t e;
    e.addr = m_base + m_stride * 32'(m_acc);
    e.data = model_row(rows_q[0], m_n);
    e.ctrl = 5'((m_n > COLS) ? COLS : m_n);
    exp_q.push_back(e);
    void'(rows_q.pop_front());
    m_acc++;
  endtask

  task automatic drive_rows(input int gnt_delay, input int stop_writes, output int cycles);
    cycles = 0;
    while ((rows_q.size() > 0 || exp_q.size() > 0 || busy_o) && cycles < 200 &&
           !(stop_writes > 0 && tile_writes >= stop_writes)) begin
      row_valid_i = (rows_q.size() > 0);
      if (rows_q.size() > 0) row_data_i = rows_q[0];
      mem_gnt_i = (cycles >= gnt_delay);
      @(negedge clk_i);
      if (row_valid_i && row_ready_o) accept_row();
      @(posedge clk_i); #1;
      cycles++;
    end
    row_valid_i = 1'b0; mem_gnt_i = 1'b0;
    checks++;
    if (cycles >= 200) $display("FAIL drive_timeout got cycles=%0d required <200", cycles);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, interface_en_o, interface_rdwr_o, row_ready_o} !== 5'b0 ||
        interface_addr_o !== '0 || interface_wr_data_o !== '0 || interface_control_o !== 5'd0)
      $display("FAIL reset_outputs got busy=%b done=%b en=%b addr=%0d required all 0", busy_o, done_o, interface_en_o, interface_addr_o);
    else passed++;
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || interface_en_o !== 1'b0)
      $display("FAIL after_reset_idle got busy=%b done=%b en=%b required 0 0 0", busy_o, done_o, interface_en_o);
    else passed++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    int cyc, d0;
    d0 = done_cnt;
    start_tile(200, 5, 3, 4, 1);
    rows_q.push_back(mkrow(1, 2, 3, 4));
    rows_q.push_back(mkrow(5, 6, 7, 8));
    rows_q.push_back(mkrow(9, 10, 11, 12));
    drive_rows(0, 0, cyc);
    checks++;
    if (cyc > 4) $display("FAIL basic_throughput got cycles=%0d required <=4", cyc); else passed++;
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done got %0d pulses required 1", done_cnt - d0); else passed++;
    checks++;
    if (exp_q.size() !== 0 || busy_o !== 1'b0)
      $display("FAIL basic_drain got pending=%0d busy=%b required 0 0", exp_q.size(), busy_o);
    else passed++;
  endtask

  task automatic test_partial();
    int cyc, d0;
    d0 = done_cnt;
    start_tile(400, 4, 2, 3, 1);
    rows_q.push_back(mkrow(7, 8, 9, 32'hDEAD));
    rows_q.push_back(mkrow(1, 2, 3, 4));
    drive_rows(0, 0, cyc);
    start_tile(500, 1, 1, 7, 1);
    rows_q.push_back(mkrow(21, 22, 23, 24));
    drive_rows(0, 0, cyc);
    checks++;
    if (done_cnt - d0 !== 2 || exp_q.size() !== 0)
      $display("FAIL partial_done got pulses=%0d pending=%0d required 2 0", done_cnt - d0, exp_q.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    int cyc, d0, acc;
    logic [RW-1:0] r0;
    d0 = done_cnt; acc = 0;
    start_tile(200, 5, 4, 4, 1);
    r0 = mkrow(100, 101, 102, 103);
    rows_q.push_back(r0);
    rows_q.push_back(mkrow(110, 111, 112, 113));
    rows_q.push_back(mkrow(120, 121, 122, 123));
    rows_q.push_back(mkrow(130, 131, 132, 133));
    mem_gnt_i = 1'b0; row_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      row_data_i = rows_q[0];
      @(negedge clk_i);
      if (c >= 1) begin
        checks++;
        if (interface_en_o !== 1'b1 || interface_addr_o !== 32'd200 || interface_wr_data_o !== r0)
          $display("FAIL bp_stable cycle=%0d got en=%b addr=%0d data=%h required 1 200 %h",
                   c, interface_en_o, interface_addr_o, interface_wr_data_o, r0);
        else passed++;
      end
      if (row_ready_o) begin accept_row(); acc++; end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    checks++;
    if (acc !== 2 || row_ready_o !== 1'b0)
      $display("FAIL bp_accept got accepted=%0d ready=%b required 2 0", acc, row_ready_o);
    else passed++;
    @(posedge clk_i); #1;
    drive_rows(0, 0, cyc);
    checks++;
    if (cyc > 4) $display("FAIL bp_full_pushpop got cycles=%0d required <=4", cyc); else passed++;
    checks++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || tile_writes !== 4)
      $display("FAIL bp_drain got pulses=%0d pending=%0d writes=%0d required 1 0 4", done_cnt - d0, exp_q.size(), tile_writes);
    else passed++;
  endtask

  task automatic test_degenerate();
    int d0;
    d0 = done_cnt;
    start_tile(300, 1, 0, 4, 1);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || interface_en_o !== 1'b0)
      $display("FAIL m0_done got done=%b busy=%b en=%b required 1 0 0", done_o, busy_o, interface_en_o);
    else passed++;
    @(posedge clk_i); #1;
    checks++;
    if (done_o !== 1'b0) $display("FAIL m0_done_pulse got done=%b required 0", done_o); else passed++;
    start_tile(310, 1, 2, 0, 1);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL n0_done got done=%b busy=%b required 1 0", done_o, busy_o);
    else passed++;
    repeat (3) @(posedge clk_i); #1;
    checks++;
    if (done_cnt - d0 !== 2 || tile_writes !== 0)
      $display("FAIL degenerate_count got pulses=%0d writes=%0d required 2 0", done_cnt - d0, tile_writes);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int cyc, d0;
    d0 = done_cnt;
    start_tile(1000, 3, 2, 4, 1);
    start_tile(0, 0, 5, 1, 0);
    rows_q.push_back(mkrow(31, 32, 33, 34));
    rows_q.push_back(mkrow(41, 42, 43, 44));
    drive_rows(0, 0, cyc);
    checks++;
    if (done_cnt - d0 !== 1 || tile_writes !== 2 || busy_o !== 1'b0)
      $display("FAIL busy_start got pulses=%0d writes=%0d busy=%b required 1 2 0", done_cnt - d0, tile_writes, busy_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    d0 = done_cnt;
    start_tile(50, 1, 4, 4, 1);
    for (int i = 0; i < 4; i++) rows_q.push_back(mkrow(32'(i), 32'(i + 10), 32'(i + 20), 32'(i + 30)));
    drive_rows(0, 1, cyc);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, interface_en_o, interface_rdwr_o, row_ready_o} !== 5'b0 ||
        interface_addr_o !== '0 || interface_wr_data_o !== '0 || interface_control_o !== 5'd0)
      $display("FAIL midreset_outputs got busy=%b done=%b en=%b addr=%0d required all 0", busy_o, done_o, interface_en_o, interface_addr_o);
    else passed++;
    exp_q.delete(); rows_q.delete();
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (done_cnt !== d0 || busy_o !== 1'b0)
      $display("FAIL midreset_nodone got pulses=%0d busy=%b required 0 0", done_cnt - d0, busy_o);
    else passed++;
    start_tile(60, 2, 2, 4, 1);
    rows_q.push_back(mkrow(5, 6, 7, 8));
    rows_q.push_back(mkrow(9, 10, 11, 12));
    drive_rows(0, 0, cyc);
    checks++;
    if (done_cnt - d0 !== 1 || tile_writes !== 2)
      $display("FAIL midreset_restart got pulses=%0d writes=%0d required 1 2", done_cnt - d0, tile_writes);
    else passed++;
  endtask

  task automatic test_relu();
    int cyc, d0;
    d0 = done_cnt;
    start_tile(700, 1, 1, 4, 1);
    rows_q.push_back(mkrow(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'd0));
    drive_rows(0, 0, cyc);
    checks++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0)
      $display("FAIL relu_done got pulses=%0d pending=%0d required 1 0", done_cnt - d0, exp_q.size());
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got time limit reached required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_degenerate();
    test_start_while_busy();
    test_reset_mid();
    test_relu();
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
